apb_rr_master: RTL

Two-requester APB master that shares a single APB completer (the 128×32 register/RAM slave in the FIFO subsystem) between two local clients. It arbitrates round-robin, sequences the APB SETUP and ACCESS phases, waits for PREADY, and returns read data and error status to the granted client. Local clients use a simple req/done handshake and never drive APB directly.

---
 rtl/apb_ctrl_pkg.sv | 16 +
 rtl/apb_rr_master_if.sv | 28 ++
 rtl/apb_rr_master_rr_arb2.sv | 24 ++
 rtl/apb_rr_master.sv | 131 +++++++++++++
 4 files changed

// File: rtl/apb_ctrl_pkg.sv
// rtl/apb_ctrl_pkg.sv - shared types and defaults for the round-robin APB master
package apb_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

  typedef logic client_id_t;

endpackage

// File: rtl/apb_rr_master_if.sv
// rtl/apb_rr_master_if.sv - APB bus bundle with master/slave views
interface apb_rr_master_if
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic [ADDR_W-1:0] PADDR;
  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PADDR, PSELx, PENABLE, PWRITE, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_rr_master_rr_arb2.sv
// rtl/apb_rr_master_rr_arb2.sv - combinational two-way round-robin arbiter
module rr_arb2
  import apb_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  client_id_t last_gnt,
  input  logic       enable,
  output logic [1:0] gnt
);

  // one-hot grant; on contention the client that did not win last time goes next
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - two-client round-robin APB master; APB_TIMEOUT_EN adds an ACCESS timeout
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic [1:0]        req_i,
  input  logic [1:0]        we_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata0_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [1:0]        done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  apb_rr_master_if.master   apb
);

  apb_state_t state;
  apb_state_t state_nxt;
  client_id_t last_gnt;
  client_id_t id;
  client_id_t win_id;
  logic [1:0] gnt;
  logic       grant;
  logic       tmo_hit;

  // arbitration is only offered while the bus is idle
  rr_arb2 u_arb (
    .req      (req_i),
    .last_gnt (last_gnt),
    .enable   (state == IDLE),
    .gnt      (gnt)
  );

  assign grant  = |gnt;
  assign win_id = gnt[1];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;

  // count ACCESS cycles spent waiting for PREADY, restarting with every grant
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tmo_cnt <= '0;
    end else if (grant) begin
      tmo_cnt <= '0;
    end else if (state == ACCESS && !apb.PREADY) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // abort on the wait cycle that brings the count to TIMEOUT_CYCLES; PREADY in that cycle wins
  assign tmo_hit = (state == ACCESS) && !apb.PREADY &&
                   (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  // constant 0: ACCESS waits for PREADY indefinitely and TIMEOUT_CYCLES has no effect
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  // state register
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (apb.PREADY || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // bus phase strobes and the completion pulse decode straight from the state
  always_comb begin
    apb.PSELx   = 1'b0;
    apb.PENABLE = 1'b0;
    done_o      = 2'b00;
    case (state)
      SETUP:   apb.PSELx = 1'b1;
      ACCESS: begin
        apb.PSELx   = 1'b1;
        apb.PENABLE = 1'b1;
      end
      DONE:    done_o = id ? 2'b10 : 2'b01;
      default: ;
    endcase
  end

  // operands latch at grant; the response is captured at the end of ACCESS and dropped after DONE
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      last_gnt   <= 1'b1;
      id         <= 1'b0;
      apb.PADDR  <= '0;
      apb.PWRITE <= 1'b0;
      apb.PWDATA <= '0;
      rdata_o    <= '0;
      err_o      <= 1'b0;
    end else begin
      if (grant) begin
        last_gnt   <= win_id;
        id         <= win_id;
        apb.PWRITE <= we_i[win_id];
        apb.PADDR  <= win_id ? addr1_i  : addr0_i;
        apb.PWDATA <= win_id ? wdata1_i : wdata0_i;
      end
      if (state == ACCESS && apb.PREADY) begin
        rdata_o <= apb.PWRITE ? '0 : apb.PRDATA;
        err_o   <= apb.PSLVERR;
      end else if (tmo_hit) begin
        rdata_o <= '0;
        err_o   <= 1'b1;
      end else if (state == DONE) begin
        rdata_o <= '0;
        err_o   <= 1'b0;
      end
    end
  end

endmodule
